data_memory_ctrl: RTL

DATA_MEMORY_CTRL -- requirements
Module: data_memory_ctrl

---
 rtl/mem_pkg.sv | 26 ++
 rtl/mem_array.sv | 25 ++
 rtl/data_memory_ctrl.sv | 100 ++++++++++
 3 files changed

// File: rtl/mem_pkg.sv
// Shared definitions for the data memory controller: word width, FSM
// state encoding, captured-request layout and the address legality check.
package mem_pkg;

  localparam int WORD_W = 32;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_WAIT = 2'd1,
    ST_ACK  = 2'd2
  } state_e;

  // Request fields latched when a request is accepted in IDLE.
  typedef struct packed {
    logic              we;
    logic [31:0]       addr;
    logic [WORD_W-1:0] wdata;
  } req_t;

  // A byte address is usable when it is word aligned and its word index
  // falls inside the array.
  function automatic logic addr_ok(input logic [31:0] addr, input int unsigned depth);
    return (addr[1:0] == 2'b00) && ({2'b00, addr[31:2]} < depth);
  endfunction

endpackage

// File: rtl/mem_array.sv
// DEPTH x WORD_W storage: synchronous write, combinational read, single
// shared address. Contents are never reset.
module mem_array
  import mem_pkg::*;
#(
  parameter int DEPTH = 256,
  parameter int AW    = 8
) (
  input  logic              clk_i,
  input  logic              we_i,
  input  logic [AW-1:0]     addr_i,
  input  logic [WORD_W-1:0] wdata_i,
  output logic [WORD_W-1:0] rdata_o
);

  logic [WORD_W-1:0] mem_q [DEPTH];

  // Write port: commits on the rising edge when enabled.
  always_ff @(posedge clk_i) begin
    if (we_i) mem_q[addr_i] <= wdata_i;
  end

  assign rdata_o = mem_q[addr_i];

endmodule

// File: rtl/data_memory_ctrl.sv
// CPU-facing memory controller: accepts one request in IDLE, waits a fixed
// LATENCY, then acknowledges for one cycle with read data or an error.
// Writes land in the array on the edge that leaves ACK.
module data_memory_ctrl
  import mem_pkg::*;
#(
  parameter int DEPTH   = 256,
  parameter int LATENCY = 4
) (
  input  logic              clk_i,
  input  logic              rst_i,
  input  logic              req_i,
  input  logic              we_i,
  input  logic [31:0]       addr_i,
  input  logic [WORD_W-1:0] wdata_i,
  output logic              busy_o,
  output logic              ack_o,
  output logic [WORD_W-1:0] rdata_o,
  output logic              err_o
);

  localparam int         AW       = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam logic [3:0] CNT_INIT = 4'(LATENCY - 1);

  state_e            state_q, state_d;
  logic [3:0]        cnt_q, cnt_d;
  req_t              req_q, req_d;
  logic              valid;
  logic              mem_we;
  logic [WORD_W-1:0] mem_rdata;

  assign valid = addr_ok(req_q.addr, DEPTH);

  mem_array #(
    .DEPTH (DEPTH),
    .AW    (AW)
  ) u_mem (
    .clk_i   (clk_i),
    .we_i    (mem_we),
    .addr_i  (req_q.addr[2 +: AW]),
    .wdata_i (req_q.wdata),
    .rdata_o (mem_rdata)
  );

  // State, latency counter and captured request registers.
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      state_q <= ST_IDLE;
      cnt_q   <= '0;
      req_q   <= '0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      req_q   <= req_d;
    end
  end

  // Next state: capture in IDLE, count down in WAIT, single-cycle ACK.
  // WAIT leaves when the counter holds 1, so ACK appears LATENCY-1 edges
  // after the accepting edge.
  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    req_d   = req_q;
    unique case (state_q)
      ST_IDLE: begin
        if (req_i) begin
          req_d   = '{we: we_i, addr: addr_i, wdata: wdata_i};
          cnt_d   = CNT_INIT;
          state_d = (LATENCY == 1) ? ST_ACK : ST_WAIT;
        end
      end
      ST_WAIT: begin
        cnt_d = cnt_q - 4'd1;
        if (cnt_q == 4'd1) state_d = ST_ACK;
      end
      ST_ACK:  state_d = ST_IDLE;
      default: state_d = ST_IDLE;
    endcase
  end

  // Outputs: completion strobe, error, read data and write enable in ACK.
  // An asserted reset suppresses the ack and the write of the aborted request.
  always_comb begin
    busy_o  = (state_q != ST_IDLE);
    ack_o   = 1'b0;
    err_o   = 1'b0;
    rdata_o = '0;
    mem_we  = 1'b0;
    if (state_q == ST_ACK && !rst_i) begin
      ack_o = 1'b1;
      err_o = ~valid;
      if (valid) begin
        if (req_q.we) mem_we  = 1'b1;
        else          rdata_o = mem_rdata;
      end
    end
  end

endmodule
